// File: rtl/regfile_writeback.sv
// regfile_writeback -- write-side front end for the register bank.
//
// Results from the load unit (mem_*) and the ALU (alu_*) are accepted into a
// small in-order FIFO and drained one per clock into the bank's single write
// port (we/ain/din). Two forwarding lookups (rs/ra) expose the youngest queued
// value for a register that has not yet retired to the bank.
//
// Optional feature macro: WB_FWD_INCOMING_EN
//   defined   -> forwarding also matches the result being accepted this cycle,
//                which counts as younger than every queued entry
//   undefined -> only queued entries are searched
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   mem_valid/ready/rd/data load unit handshake (fixed priority over ALU)
//   alu_valid/ready/rd/data ALU handshake
//   wr_hold                 bank write port unavailable this cycle
//   we, ain, din            bank write port, driven from the queue head
//   rs, ra                  forwarding queries
//   rs_hit/rs_fwd, ra_hit/ra_fwd  forwarding results (fwd=0 when no hit)
//   full, empty             queue occupancy flags
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              wr_hold,
  output logic              we,
  output logic [ADDR_W-1:0] ain,
  output logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] ra,
  output logic              rs_hit,
  output logic [DATA_W-1:0] rs_fwd,
  output logic              ra_hit,
  output logic [DATA_W-1:0] ra_fwd,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [ADDR_W-1:0] RD_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [ADDR_W-1:0] rd_mem_r   [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;

  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              can_push_s;
  logic              mem_fire_s;
  logic              alu_fire_s;
  logic              push_s;
  logic [ADDR_W-1:0] push_rd_s;
  logic [DATA_W-1:0] push_data_s;
  logic              rs_hit_s;
  logic [DATA_W-1:0] rs_fwd_s;
  logic              ra_hit_s;
  logic [DATA_W-1:0] ra_fwd_s;

  assign empty_s    = (count_r == {(PTR_W+1){1'b0}});
  assign full_s     = (count_r == DEPTH_C);
  assign pop_s      = !empty_s && !wr_hold;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign can_push_s = !full_s || pop_s;

  assign mem_ready  = can_push_s;
  assign alu_ready  = can_push_s && !mem_valid;
  assign mem_fire_s = mem_valid && can_push_s;
  assign alu_fire_s = alu_valid && can_push_s && !mem_valid;

  // Select the granted producer; writes to r0 are acknowledged but dropped.
  always_comb begin
    push_rd_s   = RD_ZERO;
    push_data_s = DATA_ZERO;
    if (mem_fire_s) begin
      push_rd_s   = mem_rd;
      push_data_s = mem_data;
    end else begin
      push_rd_s   = alu_rd;
      push_data_s = alu_data;
    end
  end

  assign push_s = (mem_fire_s || alu_fire_s) && (push_rd_s != RD_ZERO);

  assign we    = pop_s;
  assign ain   = rd_mem_r[head_r];
  assign din   = data_mem_r[head_r];
  assign full  = full_s;
  assign empty = empty_s;

  // Queue pointers and occupancy; reset drops every pending write.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      rd_mem_r[tail_r]   <= push_rd_s;
      data_mem_r[tail_r] <= push_data_s;
    end
  end

  // Forwarding scan from oldest to youngest, so later matches override.
  always_comb begin : fwd_scan
    logic [PTR_W-1:0] idx_v;
    logic             live_v;
    logic             rs_m_v;
    logic             ra_m_v;
    idx_v    = {PTR_W{1'b0}};
    live_v   = 1'b0;
    rs_m_v   = 1'b0;
    ra_m_v   = 1'b0;
    rs_hit_s = 1'b0;
    rs_fwd_s = DATA_ZERO;
    ra_hit_s = 1'b0;
    ra_fwd_s = DATA_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      idx_v    = head_r + PTR_W'(i);
      live_v   = ((PTR_W+1)'(i) < count_r);
      rs_m_v   = live_v && (rd_mem_r[idx_v] == rs) && (rs != RD_ZERO);
      ra_m_v   = live_v && (rd_mem_r[idx_v] == ra) && (ra != RD_ZERO);
      rs_hit_s = rs_hit_s || rs_m_v;
      rs_fwd_s = rs_m_v ? data_mem_r[idx_v] : rs_fwd_s;
      ra_hit_s = ra_hit_s || ra_m_v;
      ra_fwd_s = ra_m_v ? data_mem_r[idx_v] : ra_fwd_s;
    end
`ifdef WB_FWD_INCOMING_EN
    // The result accepted this cycle is younger than anything queued.
    rs_m_v   = push_s && (push_rd_s == rs);
    ra_m_v   = push_s && (push_rd_s == ra);
    rs_hit_s = rs_hit_s || rs_m_v;
    rs_fwd_s = rs_m_v ? push_data_s : rs_fwd_s;
    ra_hit_s = ra_hit_s || ra_m_v;
    ra_fwd_s = ra_m_v ? push_data_s : ra_fwd_s;
`else
    rs_m_v   = 1'b0;
    ra_m_v   = 1'b0;
`endif
  end

  assign rs_hit = rs_hit_s;
  assign rs_fwd = rs_fwd_s;
  assign ra_hit = ra_hit_s;
  assign ra_fwd = ra_fwd_s;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback -- self-checking bench for regfile_writeback.
// A queue-based reference model predicts every output each cycle; directed
// scenarios add literal expectations, then a randomized phase follows.
module tb_regfile_writeback;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              wr_hold;
  logic              we;
  logic [ADDR_W-1:0] ain;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] rs, ra;
  logic              rs_hit, ra_hit;
  logic [DATA_W-1:0] rs_fwd, ra_fwd;
  logic              full, empty;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;
  ent_t q[$];

  regfile_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .wr_hold(wr_hold), .we(we), .ain(ain), .din(din),
    .rs(rs), .ra(ra), .rs_hit(rs_hit), .rs_fwd(rs_fwd), .ra_hit(ra_hit), .ra_fwd(ra_fwd),
    .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: which producer is granted this cycle and whether it enqueues.
  function automatic logic model_can_push();
    return (q.size() < DEPTH) || (q.size() > 0 && !wr_hold);
  endfunction

  // Model update at the clock edge: retire the head, then append the accepted result.
  always @(posedge clock) begin
    logic cp;
    cp = model_can_push();
    if (reset) begin
      q.delete();
    end else begin
      if (q.size() > 0 && !wr_hold) void'(q.pop_front());
      if (mem_valid && cp) begin
        if (mem_rd != 0) q.push_back('{mem_rd, mem_data});
      end else if (alu_valid && cp) begin
        if (alu_rd != 0) q.push_back('{alu_rd, alu_data});
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    logic cp, pop, rh, ah, inc_v;
    logic [DATA_W-1:0] rf, af;
    ent_t inc;
    if (chk_en) begin
      pop = (q.size() > 0) && !wr_hold;
      cp  = model_can_push();
      rh = 1'b0; ah = 1'b0; rf = '0; af = '0;
      foreach (q[i]) begin
        if (rs != 0 && q[i].rd == rs) begin rh = 1'b1; rf = q[i].data; end
        if (ra != 0 && q[i].rd == ra) begin ah = 1'b1; af = q[i].data; end
      end
      inc_v = 1'b0;
      inc   = '0;
      if (mem_valid && cp) begin inc_v = (mem_rd != 0); inc = '{mem_rd, mem_data}; end
      else if (alu_valid && cp) begin inc_v = (alu_rd != 0); inc = '{alu_rd, alu_data}; end
`ifdef WB_FWD_INCOMING_EN
      if (inc_v && inc.rd == rs) begin rh = 1'b1; rf = inc.data; end
      if (inc_v && inc.rd == ra) begin ah = 1'b1; af = inc.data; end
`endif
      check("m_empty", empty, q.size() == 0);
      check("m_full", full, q.size() == DEPTH);
      check("m_we", we, pop);
      if (pop) begin
        check("m_ain", ain, q[0].rd);
        check("m_din", din, q[0].data);
      end
      check("m_mem_ready", mem_ready, cp);
      check("m_alu_ready", alu_ready, cp && !mem_valid);
      check("m_rs_hit", rs_hit, rh);
      check("m_rs_fwd", rs_fwd, rf);
      check("m_ra_hit", ra_hit, ah);
      check("m_ra_fwd", ra_fwd, af);
    end
  end

  initial begin
    logic mem_seen, alu_seen;
    reset = 1'b1; mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0; wr_hold = 1'b0; rs = '0; ra = '0;
    tick();
    tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    #2;
    check("reset_empty", empty, 1'b1);
    check("reset_full", full, 1'b0);
    check("reset_we", we, 1'b0);
    check("reset_alu_ready", alu_ready, 1'b1);

    // 1: single ALU write, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
    #2 check("t1_alu_ready", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0; rs = 5'd3;
    #2;
    check("t1_we", we, 1'b1);
    check("t1_ain", ain, 32'd3);
    check("t1_din", din, 32'h1234);
    check("t1_rs_hit_popping", rs_hit, 1'b1);
    tick();
    rs = '0;
    #2 check("t1_empty", empty, 1'b1);

    // 2: fill under hold, then drain in order
    wr_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(4 + k); alu_data = 32'hA0 + 32'(k);
      tick();
    end
    alu_rd = 5'd20;
    #2;
    check("t2_full", full, 1'b1);
    check("t2_alu_ready", alu_ready, 1'b0);
    tick();
    alu_valid = 1'b0; wr_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("t2_we", we, 1'b1);
      check("t2_ain", ain, 32'(4 + k));
      tick();
    end
    #2 check("t2_empty", empty, 1'b1);

    // 3: simultaneous producers, mem wins
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h80;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h90;
    #2;
    check("t3_mem_ready", mem_ready, 1'b1);
    check("t3_alu_ready", alu_ready, 1'b0);
    tick();
    mem_valid = 1'b0;
    #2;
    check("t3_alu_ready2", alu_ready, 1'b1);
    check("t3_ain8", ain, 32'd8);
    tick();
    alu_valid = 1'b0;
    #2 check("t3_ain9", ain, 32'd9);
    tick();

    // 4: youngest-wins forwarding, query 0 never hits
    wr_hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h11;
    tick();
    alu_data = 32'h22;
    tick();
    alu_valid = 1'b0; rs = 5'd10; ra = 5'd0;
    #2;
    check("t4_rs_hit", rs_hit, 1'b1);
    check("t4_rs_fwd", rs_fwd, 32'h22);
    check("t4_ra_hit", ra_hit, 1'b0);
    check("t4_ra_fwd", ra_fwd, 32'h0);
    wr_hold = 1'b0;
    tick();
    tick();
    rs = '0;

    // 5: r0 write is acknowledged but discarded
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    #2 check("t5_alu_ready", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    #2;
    check("t5_we", we, 1'b0);
    check("t5_empty", empty, 1'b1);

    // 6: reset mid-operation, then push+pop while full
    wr_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(11 + k); alu_data = 32'hB0 + 32'(k);
      tick();
    end
    alu_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; wr_hold = 1'b0;
    #2;
    check("t6_empty", empty, 1'b1);
    check("t6_we", we, 1'b0);
    tick();
    wr_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(14 + k); alu_data = 32'hC0 + 32'(k);
      tick();
    end
    wr_hold = 1'b0; alu_rd = 5'd18; alu_data = 32'hC4;
    #2;
    check("t6_full_pp", full, 1'b1);
    check("t6_alu_ready_full", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    #2;
    check("t6_still_full", full, 1'b1);
    check("t6_ain15", ain, 32'd15);
    for (int k = 0; k < 6; k++) tick();

    // Randomized traffic with producer hold-stable protocol
    mem_seen = 1'b1; alu_seen = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!(mem_valid && !mem_seen)) begin
        mem_valid = ($urandom_range(0, 99) < 40);
        mem_rd    = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      if (!(alu_valid && !alu_seen)) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      wr_hold = ($urandom_range(0, 99) < 35);
      rs      = 5'($urandom_range(0, 7));
      ra      = 5'($urandom_range(0, 7));
      reset   = ($urandom_range(0, 99) == 0);
      #2;
      mem_seen = mem_ready;
      alu_seen = alu_ready;
      tick();
    end
    reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0; wr_hold = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    #2 check("final_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write-side front end for the register bank. It accepts results from two producers, the ALU and the load unit, and queues them in a small in-order FIFO. It drains the FIFO into the bank's single sequential write port (we/ain/din), at most one write per clock. It also gives the decode stage forwarding lookups, so queued writes that have not yet retired to the bank stay visible to the two read ports (rs/ra).

Parameters:
DEPTH, 4, number of pending-write entries; power of two, ≥2
ADDR_W, 5, register index width (32 registers)
DATA_W, 32, register data width

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears queue state
mem_valid  in  1  load unit presents a result
mem_ready  out  1  load result accepted this cycle
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load result
alu_valid  in  1  ALU presents a result
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
wr_hold  in  1  bank write port unavailable this cycle (debug/CSR access)
we  out  1  to register bank write enable
ain  out  ADDR_W  to register bank write address
din  out  DATA_W  to register bank write data
rs  in  ADDR_W  forwarding query A (same index driven to bank)
ra  in  ADDR_W  forwarding query B
rs_hit  out  1  pending write to rs exists
rs_fwd  out  DATA_W  youngest pending value for rs
ra_hit  out  1  pending write to ra exists
ra_fwd  out  DATA_W  youngest pending value for ra
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- State: circular buffer of DEPTH {rd, data} entries, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Pop: pop = !empty && !wr_hold. The head is driven combinationally: we = pop, ain = head.rd, din = head.data. The entry retires at the posedge.
- Accept: can_push = !full || pop. mem has fixed priority.
  - mem_ready = can_push.
  - alu_ready = can_push && !mem_valid.
  - At most one push per cycle.
- Handshake: a transfer occurs on valid && ready at the posedge. Producers hold rd/data stable while valid && !ready.
- r0 writes (rd == 0): accepted normally (ready follows the rule above) but discarded. Not enqueued, no we, count unchanged. r0 is never written.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal even when full.
- Latency: a result accepted at edge N with an empty queue and wr_hold low has we=1 during cycle N+1 and is written to the bank at edge N+1.
- Ordering: bank writes occur in acceptance order. Two writes to the same rd retire oldest first.
- Forwarding:
  - For each query, scan valid entries (head..tail-1) and select the youngest entry with rd == query.
  - Query 0 never hits. hit=0 returns fwd=0.
  - The head entry being popped this cycle still counts as pending.
- Reset: count=0, head=tail=0.
  - Outputs: we=0, empty=1, full=0, mem_ready=alu_ready=1, alu_ready=1 only when mem_valid=0.
  - rs_hit=ra_hit=0, fwd=0. Entry storage is not cleared.
- Reset mid-operation: all queued writes are dropped and none reach the bank after the reset edge. Producers must re-present.

Optional Feature:
WB_FWD_INCOMING_EN
- Defined:
  - Forwarding also matches the result being accepted this cycle (granted producer with valid && ready, rd != 0), combinationally.
  - That result beats all queued entries as youngest.
- Undefined:
  - Only queued entries are searched.
  - Decode must stall one cycle on a same-cycle producer.

Test Plan:
1. Reset, then alu_valid with rd=3, data=0x1234 for one cycle, wr_hold=0 -> alu_ready=1. Next cycle we=1, ain=3, din=0x1234, then empty=1.
2. Hold wr_hold=1 and push ALU results to rd=4..7 with data 0xA0..0xA3 -> full=1 after the 4th accept, alu_ready=0. Release hold -> we pulses 4 cycles in order 4,5,6,7.
3. mem_valid and alu_valid both high, same cycle, rd=8 and rd=9 -> mem accepted first, alu_ready=0. ALU accepted the following cycle. Bank writes occur to 8 then 9.
4. With wr_hold=1, queue rd=10 with 0x11 then rd=10 with 0x22. Query rs=10 -> rs_hit=1, rs_fwd=0x22. Query ra=0 -> ra_hit=0.
5. Push rd=0 with data 0xDEAD -> accepted, no we pulse, count stays 0.
6. Queue 3 entries with wr_hold=1, then assert reset for one cycle -> empty=1 and no we afterwards. With the queue full and wr_hold=0, a simultaneous push and pop keeps full=1.
